// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram -- dual-read, single-write word-addressed memory
//
// Two combinational read ports share one storage array: an instruction port
// (read only) and a data port (read and write).  Writes happen on the rising
// clock edge; reads reflect the array contents with zero latency, so a read
// at the address being written shows the old word until the edge and the
// new word after it.
//
// Optional feature (macro RAM_CLEAR_EN):
//   When defined, a reset-clear sequencer zeroes every word, one per clock,
//   after reset is released.  While it runs, busy is high and external
//   writes are ignored.  A reset during the clear restarts it at address 0.
//   When undefined, reset only blocks writes and busy is tied low.
//
// Parameters:
//   DATA_WIDTH    word width in bits
//   ADDR_WIDTH    word-address width; depth is 2**ADDR_WIDTH words
//
// Ports:
//   clock         single clock, rising edge
//   reset         synchronous, active-low
//   i_address     instruction-port word address
//   i_read_data   word at i_address (combinational)
//   wEn           data-port write enable, active-high
//   d_address     data-port word address (read and write)
//   d_write_data  word written at d_address when wEn is high
//   d_read_data   word at d_address (combinational)
//   busy          high while the reset-clear sequence runs
// ---------------------------------------------------------------------------
module ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Storage; contents are undefined at power-up unless preloaded.
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Single write port shared by external writes and the clear sequencer.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

`ifdef RAM_CLEAR_EN

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt;

  // Reset wins from any state, so a reset mid-clear restarts at address 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_en       = 1'b0;
    wr_addr     = d_address;
    wr_data     = d_write_data;
    if (reset) begin
      unique case (state)
        IDLE: begin
          wr_en = wEn;
        end
        CLEAR: begin
          wr_en       = 1'b1;
          wr_addr     = clr_cnt;
          wr_data     = '0;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CLEAR);

`else

  always_comb begin
    wr_en   = reset & wEn;
    wr_addr = d_address;
    wr_data = d_write_data;
  end

  assign busy = 1'b0;

`endif

  always_ff @(posedge clock) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  assign i_read_data = ram[i_address];
  assign d_read_data = ram[d_address];

endmodule

// File: tb/tb_ram.sv
module tb_ram;

`ifdef RAM_CLEAR_EN
  localparam int AW = 4;
`else
  localparam int AW = 16;
`endif
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wEn = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [AW-1:0] d_address = '0;
  logic [DW-1:0] d_write_data = '0;
  logic [DW-1:0] i_read_data;
  logic [DW-1:0] d_read_data;
  logic          busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: word address -> expected contents.
  logic [DW-1:0] mdl [int];

  ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) uut (
    .clock       (clock),
    .reset       (reset),
    .i_address   (i_address),
    .i_read_data (i_read_data),
    .wEn         (wEn),
    .d_address   (d_address),
    .d_write_data(d_write_data),
    .d_read_data (d_read_data),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int a);
    return a & (DEPTH - 1);
  endfunction

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  // External write through the data port; caller guarantees reset=1, idle.
  task automatic wr(input int a, input logic [DW-1:0] d);
    wEn          = 1'b1;
    d_address    = AW'(a);
    d_write_data = d;
    edge1();
    wEn          = 1'b0;
    mdl[key(a)]  = d;
  endtask

  task automatic rd_chk(input string tag, input int a);
    d_address = AW'(a);
    #1;
    chk(tag, d_read_data, mdl[key(a)]);
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      edge1();
      cnt++;
    end
    chk(tag, DW'(cnt), DW'(DEPTH));
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
  endtask

  initial begin
    logic [DW-1:0] words [7];
    int            win [$];
    int            da, ia;
    logic          we;
    logic [DW-1:0] wd;

    words = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
              32'hCAFE_F00D, 32'h1357_9BDF, 32'h2468_ACE0};

    // Reset
    reset = 1'b0;
    edge1();
    edge1();
`ifdef RAM_CLEAR_EN
    chk("busy_in_reset", DW'(busy), DW'(1'b1));
    reset = 1'b1;
    wait_clear("clear_len_init");
    rd_chk("clear_word15", DEPTH - 1);
`else
    chk("busy_reset", DW'(busy), '0);
    reset = 1'b1;
    edge1();
    chk("busy_idle", DW'(busy), '0);
`endif

    // Instruction port: preloaded words, no clock edge between lookups
    for (int k = 0; k < 7; k++) begin
      uut.ram[k] = words[k];
      mdl[k]     = words[k];
    end
    for (int k = 0; k < 7; k++) begin
      i_address = AW'(k);
      #1;
      chk($sformatf("iport_%0d", k), i_read_data, words[k]);
    end

    // Write sequence 0/4/8 <- 0/1/2
    for (int k = 0; k < 3; k++) begin
      wr(4 * k, DW'(k));
      chk($sformatf("wseq_%0d", k), d_read_data, DW'(k));
    end

    // Blocked write: wEn=0 must leave address 200 alone
    wr(200, 32'hDEAD_BEEF);
    wr(201, 32'hBEEF_DEAD);
    wr(202, 32'hBEDE_ADEF);
    wEn          = 1'b0;
    d_address    = AW'(200);
    d_write_data = 32'h1234_5678;
    edge1();
    rd_chk("nowr_200", 200);
    rd_chk("nowr_201", 201);
    rd_chk("nowr_202", 202);

    // Read during write at the same address on both ports
    wr(5, 32'hAAAA_AAAA);
    d_address    = AW'(5);
    i_address    = AW'(5);
    d_write_data = 32'h5555_5555;
    wEn          = 1'b1;
    #1;
    chk("rdw_d_before", d_read_data, 32'hAAAA_AAAA);
    chk("rdw_i_before", i_read_data, 32'hAAAA_AAAA);
    edge1();
    wEn = 1'b0;
    mdl[5] = 32'h5555_5555;
    chk("rdw_d_after", d_read_data, 32'h5555_5555);
    chk("rdw_i_after", i_read_data, 32'h5555_5555);

    // Reset blocks external writes
    wr(10, 32'h0BAD_F00D);
    reset        = 1'b0;
    wEn          = 1'b1;
    d_address    = AW'(10);
    d_write_data = 32'hFFFF_FFFF;
    edge1();
    chk("rst_blk_10", d_read_data, 32'h0BAD_F00D);
`ifdef RAM_CLEAR_EN
    reset = 1'b1;
    wEn   = 1'b0;
    wait_clear("clear_len_rst");
    for (int a = 0; a < DEPTH; a++) rd_chk($sformatf("clr_zero_%0d", a), a);

    // Write while busy is ignored; reset mid-clear restarts at address 0
    for (int a = 0; a < DEPTH; a++) wr(a, $urandom() | 32'h1);
    reset = 1'b0;
    edge1();
    reset = 1'b1;
    repeat (5) edge1();
    wEn          = 1'b1;
    d_address    = AW'(2);
    d_write_data = 32'hFFFF_FFFF;
    edge1();
    wEn = 1'b0;
    chk("busy_mid", DW'(busy), DW'(1'b1));
    #1;
    chk("busy_wr_ignored", d_read_data, '0);
    edge1();
    edge1();
    rd_chk("not_yet_cleared_12", 12);
    reset = 1'b0;
    edge1();
    reset = 1'b1;
    wait_clear("clear_len_restart");
    for (int a = 0; a < DEPTH; a++) rd_chk($sformatf("restart_zero_%0d", a), a);
`else
    chk("rst_busy", DW'(busy), '0);
    edge1();
    chk("rst_blk_10b", d_read_data, 32'h0BAD_F00D);
    reset = 1'b1;
    wEn   = 1'b0;
`endif

    // Randomized traffic over a window of known addresses
    for (int a = 0; a < 16; a++) win.push_back(a);
`ifndef RAM_CLEAR_EN
    for (int a = DEPTH - 4; a < DEPTH; a++) win.push_back(a);
`endif
    foreach (win[j]) wr(win[j], $urandom());

    for (int it = 0; it < 200; it++) begin
      da = win[$urandom_range(0, win.size() - 1)];
      ia = ($urandom_range(0, 3) == 0) ? da : win[$urandom_range(0, win.size() - 1)];
      we = 1'($urandom_range(0, 1));
      wd = $urandom();
`ifndef RAM_CLEAR_EN
      reset = ($urandom_range(0, 7) != 0);
`endif
      d_address    = AW'(da);
      i_address    = AW'(ia);
      wEn          = we;
      d_write_data = wd;
      #1;
      chk($sformatf("rnd%0d_d_pre", it), d_read_data, mdl[key(da)]);
      chk($sformatf("rnd%0d_i_pre", it), i_read_data, mdl[key(ia)]);
      edge1();
      if (we && reset) mdl[key(da)] = wd;
      chk($sformatf("rnd%0d_d_post", it), d_read_data, mdl[key(da)]);
      chk($sformatf("rnd%0d_i_post", it), i_read_data, mdl[key(ia)]);
      chk($sformatf("rnd%0d_busy", it), DW'(busy), '0);
    end
    reset = 1'b1;
    wEn   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
